// File: rtl/rf_spill_fill_ctrl_pkg.sv
// rtl/rf_spill_fill_ctrl_pkg.sv - shared FSM states, transfer sizing and counter width for the spill/fill controller
package rf_spill_pkg;

  localparam int CNT_W = 32;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SPILLING  = 3'd1;
  localparam logic [2:0] ST_FILL_RD   = 3'd2;
  localparam logic [2:0] ST_FILL_LAST = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  // One window transfer moves the IN and LOCAL blocks: two blocks of n registers.
  function automatic int words_f(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/rf_spill_fill_ctrl_ram.sv
// rtl/rf_spill_fill_ctrl_ram.sv - single-port window stack RAM, synchronous write, 1-cycle synchronous read
module spill_stack_ram #(
  parameter int DW    = 64,
  parameter int DEPTH = 48,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage is never reset; read data is held until the next read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/rf_spill_fill_ctrl.sv
// rtl/rf_spill_fill_ctrl.sv - LIFO window spill/fill controller; optional perf counters under RF_SPILL_PERF_CNT_EN
module rf_spill_fill_ctrl
  import rf_spill_pkg::*;
#(
  parameter int NBITS     = 64,
  parameter int N         = 3,
  parameter int F         = 4,
  parameter int STACK_WIN = 8
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           SPILL,
  input  logic                           FILL,
  input  logic [NBITS-1:0]               MEM_BUS,
  output logic                           MEM_ACK,
  output logic [NBITS-1:0]               MEM_BUSread,
  output logic                           FILL_VALID,
  output logic                           BUSY,
  output logic                           DONE,
  output logic                           ERR_OVF,
  output logic                           ERR_UNF,
  output logic [$clog2(STACK_WIN+1)-1:0] WIN_CNT,
  output logic [CNT_W-1:0]               SPILL_CNT,
  output logic [CNT_W-1:0]               FILL_CNT
);

  localparam int WORDS = words_f(N);
  localparam int DEPTH = STACK_WIN * WORDS;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = $clog2(WORDS);
  localparam int WCW   = $clog2(STACK_WIN + 1);

  // The register file must hold at least two windows for spilling to make sense.
  if (F < 2) begin : g_f_too_small
  end

  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WCW-1:0]   win_cnt_q, win_cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             valid_q, valid_d;
  logic             data_ok_q, data_ok_d;
  logic             ram_we, ram_re;
  logic [AW-1:0]    ram_addr;
  logic [NBITS-1:0] ram_rdata;
  logic             full, empty, last_word;

  assign full      = (win_cnt_q == WCW'(STACK_WIN));
  assign empty     = (win_cnt_q == '0);
  assign last_word = (idx_q == IW'(WORDS - 1));

  // Transfer sequencing, stack pointer and sticky error flags.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    win_cnt_d = win_cnt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (SPILL) begin
          state_d = ST_SPILLING;
        end else if (FILL) begin
          state_d = ST_FILL_RD;
        end
      end
      ST_SPILLING: begin
        // A full stack still acks every word so the register file never stalls.
        ram_we   = !full;
        ram_addr = AW'(int'(win_cnt_q) * WORDS + int'(idx_q));
        idx_d    = idx_q + IW'(1);
        if (full) begin
          ovf_d = 1'b1;
        end
        if (last_word) begin
          state_d = ST_DONE;
          idx_d   = '0;
          if (!full) begin
            win_cnt_d = win_cnt_q + WCW'(1);
          end
        end
      end
      ST_FILL_RD: begin
        ram_re   = !empty;
        ram_addr = AW'((int'(win_cnt_q) - 1) * WORDS + int'(idx_q));
        idx_d    = idx_q + IW'(1);
        if (empty) begin
          unf_d = 1'b1;
        end
        if (last_word) begin
          state_d = ST_FILL_LAST;
          idx_d   = '0;
        end
      end
      ST_FILL_LAST: begin
        state_d = ST_DONE;
        if (!empty) begin
          win_cnt_d = win_cnt_q - WCW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Fill data qualifiers line up with the RAM's one-cycle read latency.
  always_comb begin
    valid_d   = (state_q == ST_FILL_RD);
    data_ok_d = (state_q == ST_FILL_RD) && !empty;
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      win_cnt_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      valid_q   <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      win_cnt_q <= win_cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      valid_q   <= valid_d;
      data_ok_q <= data_ok_d;
    end
  end

  spill_stack_ram #(
    .DW   (NBITS),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (CLK),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(MEM_BUS),
    .rdata(ram_rdata)
  );

  assign MEM_ACK     = (state_q == ST_SPILLING);
  assign BUSY        = (state_q != ST_IDLE);
  assign DONE        = (state_q == ST_DONE);
  assign FILL_VALID  = valid_q;
  // Underflow fills and idle cycles present zero rather than stale RAM data.
  assign MEM_BUSread = data_ok_q ? ram_rdata : '0;
  assign ERR_OVF     = ovf_q;
  assign ERR_UNF     = unf_q;
  assign WIN_CNT     = win_cnt_q;

`ifdef RF_SPILL_PERF_CNT_EN
  logic [CNT_W-1:0] spill_cnt_q, spill_cnt_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;

  // Saturating completed-transfer counters, visible from the DONE cycle.
  always_comb begin
    spill_cnt_d = spill_cnt_q;
    fill_cnt_d  = fill_cnt_q;
    if (state_q == ST_SPILLING && last_word && spill_cnt_q != '1) begin
      spill_cnt_d = spill_cnt_q + CNT_W'(1);
    end
    if (state_q == ST_FILL_LAST && fill_cnt_q != '1) begin
      fill_cnt_d = fill_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      spill_cnt_q <= '0;
      fill_cnt_q  <= '0;
    end else begin
      spill_cnt_q <= spill_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
    end
  end

  assign SPILL_CNT = spill_cnt_q;
  assign FILL_CNT  = fill_cnt_q;
`else
  assign SPILL_CNT = '0;
  assign FILL_CNT  = '0;
`endif

endmodule

// File: doc/rf_spill_fill_ctrl.md
# rf_spill_fill_ctrl

Spill/fill memory controller that sits directly behind the windowed register file. It consumes the register file's SPILL/FILL requests and the window words it drives on its memory bus, and stores them in an internal LIFO stack of windows. On FILL it returns the most recently spilled window, word by word, onto the register file's memory read bus. It is the only backing store for windows evicted on CALL overflow and restored on SIGRETURN underflow.

## Interface
Parameters:
- NBITS, 64, word width
- N, 3, registers per IN/OUT/LOCAL block; one window transfer is WORDS = 2*N words
- F, 4, number of windows held in the register file (informational, checked by bench)
- STACK_WIN, 8, windows the stack can hold; depth = STACK_WIN*WORDS

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- SPILL  in  1  spill request from register file
- FILL  in  1  fill request from register file
- MEM_BUS  in  NBITS  word being spilled
- MEM_ACK  out  1  word on MEM_BUS is consumed this cycle; register file advances to next word
- MEM_BUSread  out  NBITS  word being filled
- FILL_VALID  out  1  MEM_BUSread holds a valid fill word
- BUSY  out  1  transfer in progress
- DONE  out  1  one-cycle pulse at end of transfer
- ERR_OVF  out  1  sticky: spill attempted with stack full
- ERR_UNF  out  1  sticky: fill attempted with stack empty
- WIN_CNT  out  $clog2(STACK_WIN+1)  windows currently stored
- SPILL_CNT, FILL_CNT  out  32 each  perf counters (see Configuration)

## Operation
- FSM states: IDLE, SPILLING, FILL_RD, FILL_LAST, DONE.
- IDLE: SPILL → SPILLING; else FILL → FILL_RD. SPILL has priority when both are high; FILL is ignored that cycle.
- SPILLING: MEM_ACK=1 for WORDS cycles. Word i is written to address base+i, where base = WIN_CNT*WORDS. After the last word, WIN_CNT increments and the FSM moves to DONE.
- FILL_RD: issues synchronous RAM reads at addresses (WIN_CNT-1)*WORDS + i, i=0..WORDS-1. Words are returned in spill order. FILL_LAST covers the final read-data cycle. WIN_CNT decrements at the end of the transfer.
- DONE: DONE=1 for one cycle, then IDLE. SPILL/FILL are not re-sampled in DONE.
- Overflow: SPILL with WIN_CNT==STACK_WIN still runs the full handshake (MEM_ACK for WORDS cycles), but RAM writes are suppressed, WIN_CNT is unchanged, and ERR_OVF sets.
- Underflow: FILL with WIN_CNT==0 still produces WORDS FILL_VALID cycles. MEM_BUSread=0 throughout, WIN_CNT is unchanged, and ERR_UNF sets.
- ERR flags clear only on reset.
- BUSY=1 in every state except IDLE.
- Reset (async, RESET=0): all outputs are 0, FSM goes to IDLE, WIN_CNT=0, errors and counters clear. Reset mid-transfer aborts it with no DONE pulse. RAM contents are not cleared.

## Timing
Cycle c0 is the cycle in which the request is high in IDLE.
- Spill: MEM_ACK=1 in cycles c0+1..c0+WORDS. Word i is sampled at the end of cycle c0+1+i. DONE=1 in c0+WORDS+1. WIN_CNT updates in c0+WORDS+1.
- Fill: FILL_VALID=1 in cycles c0+2..c0+WORDS+1, with word i in cycle c0+2+i. DONE=1 in c0+WORDS+2.
- Back-to-back: a request held high through DONE starts the next transfer in the cycle after DONE.
- MEM_BUSread is registered and returns to 0 whenever FILL_VALID=0.

## Configuration
- RF_SPILL_PERF_CNT_EN defined: SPILL_CNT/FILL_CNT count completed transfers, including overflow/underflow ones. They increment in the DONE cycle and saturate at 2^32-1.
- Not defined: both ports are tied to 0 and no counter flops exist.

## Structure
- Shared package rf_spill_pkg holds:
  - the FSM state enum
  - the WORDS localparam function
  - the counter width constant
- Sub-module spill_stack_ram: single-port RAM, depth STACK_WIN*WORDS, NBITS wide, synchronous write, 1-cycle synchronous read.

## Test plan
- Reset mid-spill: pulse SPILL, assert RESET=0 at c0+3 → all outputs 0, WIN_CNT=0, no DONE.
- Single spill then fill, N=3: spill words 0x10..0x15 → MEM_ACK for 6 cycles, DONE at c0+7, WIN_CNT=1. Then FILL → 0x10..0x15 in cycles c0+2..c0+7, DONE at c0+8, WIN_CNT=0.
- LIFO: spill window A (0xA0..), then window B (0xB0..), then two fills → B words returned first, then A.
- Overflow: 9 spills with STACK_WIN=8 → 9th spill still gives 6 MEM_ACKs and DONE, ERR_OVF=1, WIN_CNT=8, stored data intact.
- Underflow: FILL with WIN_CNT=0 → 6 FILL_VALID cycles with MEM_BUSread=0, ERR_UNF=1.
- Simultaneous SPILL and FILL in IDLE → spill performed, fill ignored. With RF_SPILL_PERF_CNT_EN, SPILL_CNT=1 and FILL_CNT=0.
